// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch/check sequencer.
//   ADDR_W, WORD_W, LEN_W   address, word and run-length widths
//   state_t                 sequencer states
//   fifo_entry_t            {data, addr, perr} result record
//   eff_run_len()           maps a requested run length onto 1..16
package fetch_pkg;

   localparam int ADDR_W  = 4;
   localparam int WORD_W  = 8;
   localparam int LEN_W   = ADDR_W + 1;
   localparam int MAX_RUN = 1 << ADDR_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic [WORD_W-1:0] data;
      logic [ADDR_W-1:0] addr;
      logic              perr;
   } fifo_entry_t;

   // 0 means a full sweep; anything above a full sweep is clamped to it.
   function automatic logic [LEN_W-1:0] eff_run_len(input logic [LEN_W-1:0] len);
      if (len == '0 || len > LEN_W'(MAX_RUN)) begin
         return LEN_W'(MAX_RUN);
      end
      return len;
   endfunction

endpackage

// File: rtl/fetch_check_seq_if.sv
// fetch_check_seq_if: bus bundle between the sequencer, the fetch unit and
// the result consumer.
//   fetch_addr / fetch_data / fetch_parity   address out, word + stored parity back
//   out_valid / out_ready                     result stream handshake
//   out_data / out_addr / out_perr            result stream payload
// master: sequencer side.  slave: fetch unit + consumer side.
interface fetch_check_seq_if;
   import fetch_pkg::*;

   logic [ADDR_W-1:0] fetch_addr;
   logic [WORD_W-1:0] fetch_data;
   logic              fetch_parity;

   logic              out_valid;
   logic              out_ready;
   logic [WORD_W-1:0] out_data;
   logic [ADDR_W-1:0] out_addr;
   logic              out_perr;

   modport master (
      output fetch_addr,
      input  fetch_data, fetch_parity,
      output out_valid, out_data, out_addr, out_perr,
      input  out_ready
   );

   modport slave (
      input  fetch_addr,
      output fetch_data, fetch_parity,
      input  out_valid, out_data, out_addr, out_perr,
      output out_ready
   );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous circular-buffer FIFO of fifo_entry_t.
//   clk, rst        clock, synchronous active-high reset (empties and zeroes storage)
//   push_i          write push_entry_i (ignored when full)
//   push_entry_i    entry to write
//   pop_i           drop the head entry (ignored when empty)
//   head_o          current head entry
//   count_o         number of stored entries, 0..DEPTH
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  fifo_entry_t              push_entry_i,
   input  logic                     pop_i,
   output fifo_entry_t              head_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   fifo_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [CNT_W-1:0]   count_q;
   logic               do_push;
   logic               do_pop;

   assign do_push = push_i && (count_q != CNT_W'(DEPTH));
   assign do_pop  = pop_i && (count_q != '0);

   // Storage is cleared on reset so the head reads as zero after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_entry_i;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         if (do_push && !do_pop) begin
            count_q <= count_q + CNT_W'(1);
         end else if (do_pop && !do_push) begin
            count_q <= count_q - CNT_W'(1);
         end
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/fetch_check_seq.sv
// fetch_check_seq: walks a run of addresses into the two-bank parity fetch
// unit, checks even parity on each returned word and queues
// {data, addr, perr} results for a valid/ready consumer.
//   clk, rst        clock, synchronous active-high reset
//   start_i         begin a run (honoured in IDLE only)
//   base_addr_i     first address of the run
//   run_len_i       words to fetch; 0 or >16 means 16
//   bus (master)    fetch address/data/parity and result stream
//   busy_o          run in progress (registered)
//   done_o          one-cycle completion pulse (registered)
//   err_count_o     parity errors seen in the current/last run, saturating
// Build option: PARITY_CHECK_EN enables the parity check; without it perr
// is always 0 and err_count_o stays 0.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | issuing addresses and pushing results while the FIFO has room
// DRAIN | all words fetched; waiting for the consumer to empty the FIFO
module fetch_check_seq
   import fetch_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic [ADDR_W-1:0]  base_addr_i,
   input  logic [ADDR_W:0]    run_len_i,
   fetch_check_seq_if.master  bus,
   output logic               busy_o,
   output logic               done_o,
   output logic [ADDR_W:0]    err_count_o
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  fetch_addr_q, fetch_addr_d;
   logic [LEN_W-1:0]   remaining_q, remaining_d;
   logic [LEN_W-1:0]   err_q, err_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [CNT_W-1:0]   fifo_count;
   fifo_entry_t        head;
   fifo_entry_t        push_entry;
   logic               push;
   logic               pop;
   logic               perr;

`ifdef PARITY_CHECK_EN
   assign perr = (^bus.fetch_data) != bus.fetch_parity;
`else
   logic unused_parity;
   assign unused_parity = bus.fetch_parity;
   assign perr          = 1'b0;
`endif

   // Push depends on the registered count only, so out_ready never reaches
   // the fetch address path combinationally.
   assign push = (state_q == FETCH) && (fifo_count != CNT_W'(FIFO_DEPTH));
   assign pop  = bus.out_valid && bus.out_ready;

   assign push_entry = '{data: bus.fetch_data, addr: fetch_addr_q, perr: perr};

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .push_i       (push),
      .push_entry_i (push_entry),
      .pop_i        (pop),
      .head_o       (head),
      .count_o      (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         fetch_addr_q <= '0;
         remaining_q  <= '0;
         err_q        <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_addr_q <= fetch_addr_d;
         remaining_q  <= remaining_d;
         err_q        <= err_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      fetch_addr_d = fetch_addr_q;
      remaining_d  = remaining_q;
      err_d        = err_q;
      busy_d       = busy_q;
      done_d       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               fetch_addr_d = base_addr_i;
               remaining_d  = eff_run_len(run_len_i);
               err_d        = '0;
               busy_d       = 1'b1;
               state_d      = FETCH;
            end
         end
         FETCH: begin
            if (push) begin
               fetch_addr_d = fetch_addr_q + ADDR_W'(1);
               remaining_d  = remaining_q - LEN_W'(1);
               if (perr && (err_q != '1)) begin
                  err_d = err_q + LEN_W'(1);
               end
               if (remaining_q == LEN_W'(1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            // The empty case cannot normally occur; it keeps DRAIN from
            // ever becoming a dead end.
            if ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop)) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.fetch_addr = fetch_addr_q;
   assign bus.out_valid  = (fifo_count != '0);
   assign bus.out_data   = head.data;
   assign bus.out_addr   = head.addr;
   assign bus.out_perr   = head.perr;

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_count_o = err_q;

endmodule

// File: tb/tb_fetch_check_seq.sv
module tb_fetch_check_seq;
   import fetch_pkg::*;

`ifdef PARITY_CHECK_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  base;
   logic [4:0]  run_len;
   logic        busy;
   logic        done;
   logic [4:0]  err_count;

   fetch_check_seq_if bus ();

   fetch_check_seq #(.FIFO_DEPTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start),
      .base_addr_i (base),
      .run_len_i   (run_len),
      .bus         (bus),
      .busy_o      (busy),
      .done_o      (done),
      .err_count_o (err_count)
   );

   always #5 clk = ~clk;

   // Behavioural fetch unit: word and stored parity per address.
   logic [7:0] mem_data [16];
   logic       mem_par  [16];
   assign bus.fetch_data   = mem_data[bus.fetch_addr];
   assign bus.fetch_parity = mem_par[bus.fetch_addr];

   int n_tests = 0;
   int n_fail  = 0;
   fifo_entry_t exp_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string pfx);
      check({pfx, "_fetch_addr"}, 32'(bus.fetch_addr), 0);
      check({pfx, "_out_valid"},  32'(bus.out_valid), 0);
      check({pfx, "_out_data"},   32'(bus.out_data), 0);
      check({pfx, "_out_addr"},   32'(bus.out_addr), 0);
      check({pfx, "_out_perr"},   32'(bus.out_perr), 0);
      check({pfx, "_busy"},       32'(busy), 0);
      check({pfx, "_done"},       32'(done), 0);
      check({pfx, "_err_count"},  32'(err_count), 0);
   endtask

   // mode 0: out_ready high; 1: random out_ready; 2: out_ready low until
   // cycle 12 with a frozen-address check at cycle 10.
   task automatic run(input logic [3:0] b, input logic [4:0] len, input int mode,
                      input bit poke_start, output int done_cyc);
      int          n;
      int          exp_err;
      int          c;
      bit          seen_done;
      logic [3:0]  a;
      fifo_entry_t e;
      n = (len == 0 || len > 16) ? 16 : int'(len);
      exp_q.delete();
      exp_err = 0;
      for (int i = 0; i < n; i++) begin
         a = 4'((int'(b) + i) % 16);
         e.data = mem_data[a];
         e.addr = a;
         e.perr = PAR_EN && ((^mem_data[a]) != mem_par[a]);
         if (e.perr) exp_err++;
         exp_q.push_back(e);
      end

      start = 1'b1; base = b; run_len = len;
      @(negedge clk);
      start = 1'b0;
      check("busy_cycle1", 32'(busy), 1);
      check("first_addr", 32'(bus.fetch_addr), 32'(b));
      check("valid_cycle1", 32'(bus.out_valid), 0);

      seen_done = 1'b0;
      done_cyc  = -1;
      c = 1;
      while (c <= 300 && !seen_done) begin
         if (done) begin
            seen_done = 1'b1;
            done_cyc  = c;
            check("queue_left_at_done", 32'(exp_q.size()), 0);
            check("err_count_at_done", 32'(err_count), 32'(exp_err));
            check("busy_at_done", 32'(busy), 0);
            check("valid_at_done", 32'(bus.out_valid), 0);
         end else begin
            case (mode)
               0:       bus.out_ready = 1'b1;
               1:       bus.out_ready = 1'($urandom_range(0, 1));
               default: bus.out_ready = (c >= 12);
            endcase
            if (mode == 2 && c == 10) begin
               check("frozen_fetch_addr", 32'(bus.fetch_addr), 32'(4'(b + 4'd4)));
               check("full_valid", 32'(bus.out_valid), 1);
            end
            if (poke_start && c == 2) begin
               start = 1'b1; base = ~b; run_len = 5'd1;
            end else begin
               start = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
               if (exp_q.size() == 0) begin
                  check("extra_pop", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("out_data", 32'(bus.out_data), 32'(e.data));
                  check("out_addr", 32'(bus.out_addr), 32'(e.addr));
                  check("out_perr", 32'(bus.out_perr), 32'(e.perr));
               end
            end
            @(negedge clk);
            c++;
         end
      end
      if (!seen_done) check("done_timeout", 0, 1);
      @(negedge clk);
      check("done_one_cycle", 32'(done), 0);
   endtask

   initial begin
      int  dc;
      bit  saw_done;
      bit  saw_valid;
      logic [3:0] rb;
      logic [4:0] rl;

      rst = 1'b1; start = 1'b0; base = '0; run_len = '0; bus.out_ready = 1'b0;
      for (int a = 0; a < 16; a++) begin
         mem_data[a] = 8'($urandom);
         mem_par[a]  = ^mem_data[a];
      end
      mem_data[0] = 8'h1F; mem_par[0] = 1'b1;
      mem_data[7] = 8'hFD; mem_par[7] = 1'b1;
      mem_data[8] = 8'h00; mem_par[8] = 1'b0;
      mem_data[9] = 8'h22; mem_par[9] = 1'b0;

      repeat (2) @(negedge clk);
      check_reset("reset");
      rst = 1'b0;
      @(negedge clk);

      // Minimum run: word 0x1F from address 0, done in cycle 3.
      run(4'd0, 5'd1, 0, 1'b0, dc);
      check("min_run_done_cycle", 32'(dc), 3);
      check("min_run_err", 32'(err_count), 0);

      // Bank boundary 7 -> 8 -> 9.
      run(4'd7, 5'd3, 0, 1'b0, dc);

      // Address wrap 14, 15, 0, 1.
      run(4'd14, 5'd4, 1, 1'b0, dc);

      // Parity error injected at address 2.
      mem_data[2] = 8'h01; mem_par[2] = 1'b0;
      run(4'd0, 5'd4, 1, 1'b0, dc);
      check("inject_err_count", 32'(err_count), PAR_EN ? 1 : 0);

      // Backpressure with a full run, plus an ignored start during FETCH.
      run(4'd5, 5'd16, 2, 1'b1, dc);

      // run_len 0 and >16 both mean 16.
      run(4'd3, 5'd0, 1, 1'b0, dc);
      run(4'd11, 5'd20, 1, 1'b0, dc);

      // Reset mid-run: everything back to reset values, no done pulse.
      bus.out_ready = 1'b0;
      start = 1'b1; base = 4'd1; run_len = 5'd16;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset("midrun_reset");
      rst = 1'b0;
      bus.out_ready = 1'b1;
      saw_done = 1'b0; saw_valid = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
         if (bus.out_valid) saw_valid = 1'b1;
      end
      check("no_done_after_reset", 32'(saw_done), 0);
      check("no_valid_after_reset", 32'(saw_valid), 0);

      // Randomized runs with random parity corruption.
      for (int it = 0; it < 8; it++) begin
         for (int a = 0; a < 16; a++) begin
            mem_data[a] = 8'($urandom);
            mem_par[a]  = (^mem_data[a]) ^ ($urandom_range(0, 3) == 0);
         end
         rb = 4'($urandom);
         rl = 5'($urandom_range(0, 31));
         run(rb, rl, 1, 1'($urandom_range(0, 1)), dc);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
